multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM; optional bne decode under BNE_EN
module multicycle_control (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [5:0]  opcode,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
`ifdef BNE_EN
  output logic        BranchNE,
`endif
  output logic        Illegal,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'd5;
`endif

  state_t cur_state;
  state_t nxt_state;
  logic   retire;

  assign state = cur_state;

  // State register; reset parks the FSM in FETCH
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) cur_state <= FETCH;
    else        cur_state <= nxt_state;
  end

  // Retired-instruction counter; aborted and illegal instructions never retire
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      instret <= 32'd0;
    else if (retire) instret <= instret + 32'd1;
  end

  // Next-state and control decode; everything is forced low while in reset
  always_comb begin
    nxt_state   = FETCH;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    Illegal     = 1'b0;
`ifdef BNE_EN
    BranchNE    = 1'b0;
`endif
    case (cur_state)
      FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b01;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        nxt_state = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_RTYPE:     nxt_state = EXEC;
          OP_LW, OP_SW: nxt_state = MEMADR;
          OP_BEQ:       nxt_state = BRANCH;
          OP_J:         nxt_state = JUMP;
`ifdef BNE_EN
          OP_BNE:       nxt_state = BRANCH;
`endif
          default: begin
            nxt_state = FETCH;
            Illegal   = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nxt_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        nxt_state = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        retire    = 1'b1;
      end
      MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        retire    = MemReady;
        nxt_state = MemReady ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        nxt_state = RWB;
      end
      RWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
`ifdef BNE_EN
        BranchNE    = (opcode == OP_BNE);
`endif
      end
      JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        retire    = 1'b1;
      end
      default: nxt_state = FETCH;
    endcase
    if (!RESET) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      Illegal     = 1'b0;
`ifdef BNE_EN
      BranchNE    = 1'b0;
`endif
    end
  end

endmodule
